// File: rtl/fft8_pkg.sv
// Shared types, constants and helpers for the 8-point FP32 radix-2 DIT butterfly sequencer.
// FFT8_IFFT_EN adds the 1/8 output scaling helper used by the inverse transform.
package fft8_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned N_POINT  = 8;
  localparam int unsigned LOG2N    = 3;
  localparam int unsigned NUM_BFLY = 12;
  localparam int unsigned CNT_W    = 4;

  // W8^t = exp(-j*2*pi*t/8) as FP32 bit patterns
  localparam logic [DATA_W-1:0] TW0_RE = 32'h3F80_0000;
  localparam logic [DATA_W-1:0] TW0_IM = 32'h0000_0000;
  localparam logic [DATA_W-1:0] TW1_RE = 32'h3F35_04F3;
  localparam logic [DATA_W-1:0] TW1_IM = 32'hBF35_04F3;
  localparam logic [DATA_W-1:0] TW2_RE = 32'h0000_0000;
  localparam logic [DATA_W-1:0] TW2_IM = 32'hBF80_0000;
  localparam logic [DATA_W-1:0] TW3_RE = 32'hBF35_04F3;
  localparam logic [DATA_W-1:0] TW3_IM = 32'hBF35_04F3;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] i);
    return {i[0], i[1], i[2]};
  endfunction

`ifdef FFT8_IFFT_EN
  // Divide by 8 through the exponent field; underflow flushes to signed zero.
  function automatic logic [DATA_W-1:0] fp_div8(input logic [DATA_W-1:0] x);
    if (x[30:23] == 8'hFF) return x;
    if (x[30:23] <= 8'd3) return {x[31], 31'd0};
    return {x[31], x[30:23] - 8'd3, x[22:0]};
  endfunction
`endif

endpackage

// File: rtl/fft8_twiddle_rom.sv
// Twiddle lookup W8^idx; with FFT8_IFFT_EN a conjugate flag flips the imaginary sign.
module fft8_twiddle_rom
  import fft8_pkg::*;
(
  input  logic [1:0] idx,
`ifdef FFT8_IFFT_EN
  input  logic       conj,
`endif
  output cplx_t      w
);

  cplx_t base;

  always_comb begin
    base = '{re: TW0_RE, im: TW0_IM};
    case (idx)
      2'd0:    base = '{re: TW0_RE, im: TW0_IM};
      2'd1:    base = '{re: TW1_RE, im: TW1_IM};
      2'd2:    base = '{re: TW2_RE, im: TW2_IM};
      default: base = '{re: TW3_RE, im: TW3_IM};
    endcase
  end

`ifdef FFT8_IFFT_EN
  assign w = '{re: base.re, im: {base.im[DATA_W-1] ^ conj, base.im[DATA_W-2:0]}};
`else
  assign w = base;
`endif

endmodule

// File: rtl/fft8_bfly_sequencer.sv
// 8-point FP32 DIT FFT sequencer: bit-reversed load, 12 in-place butterflies on an external
// combinational unit, natural-order unload. FFT8_IFFT_EN adds i_inverse (conjugate twiddles, 1/8 scale).
module fft8_bfly_sequencer
  import fft8_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
`ifdef FFT8_IFFT_EN
  input  logic              i_inverse,
`endif
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data_re,
  input  logic [DATA_W-1:0] i_data_im,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data_re,
  output logic [DATA_W-1:0] o_data_im,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_bf_valid,
  output logic [DATA_W-1:0] o_bf_data_0_re,
  output logic [DATA_W-1:0] o_bf_data_0_im,
  output logic [DATA_W-1:0] o_bf_data_1_re,
  output logic [DATA_W-1:0] o_bf_data_1_im,
  output logic [DATA_W-1:0] o_bf_twiddle_re,
  output logic [DATA_W-1:0] o_bf_twiddle_im,
  input  logic [DATA_W-1:0] i_bf_data_0_re,
  input  logic [DATA_W-1:0] i_bf_data_0_im,
  input  logic [DATA_W-1:0] i_bf_data_1_re,
  input  logic [DATA_W-1:0] i_bf_data_1_im
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  cplx_t            mem [N_POINT];
  logic [LOG2N-1:0] idx0, idx1;
  logic [1:0]       tw_idx;
  cplx_t            tw;
  cplx_t            out_word;
  logic             in_compute;
  logic             in_unload;
  logic             conj;

  assign in_compute = (state == COMPUTE);
  assign in_unload  = (state == UNLOAD);

`ifdef FFT8_IFFT_EN
  logic inv_q;

  // Direction is latched with the first sample and held for the whole frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inv_q <= 1'b0;
    end else if (state == LOAD && i_valid && cnt == '0) begin
      inv_q <= i_inverse;
    end
  end

  assign conj = inv_q;
`else
  assign conj = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= LOAD;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      LOAD: begin
        if (i_valid) begin
          if (cnt == CNT_W'(N_POINT - 1)) begin
            cnt_nxt   = '0;
            state_nxt = COMPUTE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      COMPUTE: begin
        if (cnt == CNT_W'(NUM_BFLY - 1)) begin
          cnt_nxt   = '0;
          state_nxt = UNLOAD;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      UNLOAD: begin
        if (i_ready) begin
          if (cnt == CNT_W'(N_POINT - 1)) begin
            cnt_nxt   = '0;
            state_nxt = LOAD;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = LOAD;
      end
    endcase
  end

  // Butterfly addressing: cnt[3:2] is the stage, cnt[1:0] the butterfly within it.
  always_comb begin
    idx0   = '0;
    idx1   = '0;
    tw_idx = '0;
    case (cnt[3:2])
      2'd0: begin
        idx0 = {cnt[1:0], 1'b0};
        idx1 = {cnt[1:0], 1'b1};
      end
      2'd1: begin
        idx0   = {cnt[1], 1'b0, cnt[0]};
        idx1   = {cnt[1], 1'b1, cnt[0]};
        tw_idx = {cnt[0], 1'b0};
      end
      default: begin
        idx0   = {1'b0, cnt[1:0]};
        idx1   = {1'b1, cnt[1:0]};
        tw_idx = cnt[1:0];
      end
    endcase
  end

  fft8_twiddle_rom u_twiddle_rom (
    .idx  (tw_idx),
`ifdef FFT8_IFFT_EN
    .conj (conj),
`endif
    .w    (tw)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem <= '{default: '0};
    end else if (state == LOAD && i_valid) begin
      mem[bitrev3(cnt[LOG2N-1:0])] <= '{re: i_data_re, im: i_data_im};
    end else if (in_compute) begin
      mem[idx0] <= '{re: i_bf_data_0_re, im: i_bf_data_0_im};
      mem[idx1] <= '{re: i_bf_data_1_re, im: i_bf_data_1_im};
    end
  end

  assign out_word = mem[cnt[LOG2N-1:0]];

  assign o_ready    = (state == LOAD);
  assign o_valid    = in_unload;
  assign o_busy     = in_compute || in_unload;
  assign o_last     = in_unload && (cnt == CNT_W'(N_POINT - 1));
  assign o_bf_valid = in_compute;

`ifdef FFT8_IFFT_EN
  assign o_data_re = !in_unload ? '0 : (conj ? fp_div8(out_word.re) : out_word.re);
  assign o_data_im = !in_unload ? '0 : (conj ? fp_div8(out_word.im) : out_word.im);
`else
  assign o_data_re = in_unload ? out_word.re : '0;
  assign o_data_im = in_unload ? out_word.im : '0;
`endif

  assign o_bf_data_0_re  = in_compute ? mem[idx0].re : '0;
  assign o_bf_data_0_im  = in_compute ? mem[idx0].im : '0;
  assign o_bf_data_1_re  = in_compute ? mem[idx1].re : '0;
  assign o_bf_data_1_im  = in_compute ? mem[idx1].im : '0;
  assign o_bf_twiddle_re = in_compute ? tw.re : '0;
  assign o_bf_twiddle_im = in_compute ? tw.im : '0;

endmodule

// File: doc/fft8_bfly_sequencer.md
Name: fft8_bfly_sequencer

Overview:
Initiator side of the radix-2 butterfly interface: owns the 8-point complex working buffer, runs the 3-stage in-place DIT schedule (12 butterflies) and drives an external combinational Butterfly_Unit through dedicated operand/result ports. Samples stream in natural order through a valid/ready port and are written to bit-reversed buffer slots. Results stream out in natural order through a valid/ready port. All data is IEEE-754 FP32.

Parameters:
DATA_W, 32, FP32 word width (fixed; only 32 supported)
N_POINT, 8, transform size (fixed; only 8 supported)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  input sample valid
o_ready  out  1  sequencer accepts input sample
i_data_re  in  32  input sample real
i_data_im  in  32  input sample imaginary
o_valid  out  1  output bin valid
i_ready  in  1  downstream accepts output bin
o_data_re  out  32  output bin real
o_data_im  out  32  output bin imaginary
o_last  out  1  high with bin 7
o_busy  out  1  high in COMPUTE or UNLOAD
o_bf_valid  out  1  butterfly operands valid this cycle
o_bf_data_0_re/_im  out  32 each  operand a
o_bf_data_1_re/_im  out  32 each  operand b
o_bf_twiddle_re/_im  out  32 each  twiddle W
i_bf_data_0_re/_im  in  32 each  y0 = a + W·b (same cycle)
i_bf_data_1_re/_im  in  32 each  y1 = a − W·b (same cycle)

Behaviour:
- Reset (async, i_rst_n=0): state LOAD, counters 0, buffer cleared to 0; o_ready=1, o_valid=0, o_last=0, o_busy=0, o_bf_valid=0, o_data_*=0, o_bf_* operands/twiddle=0. Reset mid-COMPUTE or mid-UNLOAD aborts the frame; no partial output after release.
- FSM: LOAD -> COMPUTE -> UNLOAD -> LOAD.
- LOAD: o_ready=1. On i_valid&o_ready, buf[bitrev3(cnt)] <= sample, cnt++. Accepting sample 7 -> cnt=0, go COMPUTE. i_valid with o_ready=0 is ignored (not stalled, not queued).
- COMPUTE: 12 cycles; o_ready=0, o_bf_valid=1. Step j: stage s=j>>2, k=j&3, half=1<<s; idx0=((k>>s)<<(s+1))+(k&(half-1)); idx1=idx0+half; twiddle index t=(k&(half-1))<<(2-s). Operands = buf[idx0], buf[idx1]; at clock edge buf[idx0]<=y0, buf[idx1]<=y1. After step 11 go UNLOAD.
- Twiddle ROM (W8^t): t0=(3F800000,00000000), t1=(3F3504F3,BF3504F3), t2=(00000000,BF800000), t3=(BF3504F3,BF3504F3).
- UNLOAD: o_valid=1, o_data=buf[cnt] (combinational mux from registered buffer and counter), o_last=(cnt==7). On o_valid&i_ready cnt++; handshake at cnt 7 -> LOAD, cnt=0. i_ready low holds data stable.
- Latency: last input accepted at edge T -> o_valid first high after edge T+12 (12 COMPUTE cycles). Minimum frame period 28 cycles.
- o_bf_* outputs are 0 outside COMPUTE.

Optional Feature:
FFT8_IFFT_EN: adds input port i_inverse (sampled on first LOAD handshake, held for the frame). When 1: twiddle imaginary sign bit flipped (conjugate) and each UNLOAD output scaled by 1/8 via exponent−3 (exponent<=3 -> signed zero). Without macro: port absent, forward FFT only, no scaling.

Decomposition:
- fft8_pkg: DATA_W, N_POINT, LOG2N=3, NUM_BFLY=12, twiddle constants, state enum {LOAD, COMPUTE, UNLOAD}, bitrev3 function, complex struct {re, im}.
- Sub-module fft8_twiddle_rom: 2-bit index (plus conjugate flag under FFT8_IFFT_EN) -> W re/im.

Test Plan:
- Impulse x[0]=1.0 (3F800000), rest 0 -> all 8 bins re=3F800000, im=0; o_last only on bin 7.
- DC: all x=1.0 -> bin0 re=41000000 (8.0); bins 1-7 numerically zero (±0 accepted).
- x[1]=1.0 -> bin k = W8^k: bin1=(3F3504F3,BF3504F3), bin2=(0,BF800000), bin4=(BF800000,0).
- Backpressure: i_ready low 3 cycles at bin 3 -> o_data holds bin 3, no bin skipped/duplicated; o_ready stays 0 until bin 7 handshake.
- Reset asserted at COMPUTE step 5 -> outputs return to reset values immediately; next frame (impulse) produces correct result.
- FFT8_IFFT_EN, i_inverse=1: input X[k]=8.0 all k (re=41000000) -> out x[0]=8.0·8/8=8.0 (41000000), x[1..7]=0.
